alu_wb_unit: RTL and testbench
==============================

// Module: alu_wb_unit
// PURPOSE
//  Writeback end of the execute datapath: consumes ALU results (res, fo, wb_en, flag_en) and load data from memory.
//  Owns the flag register that feeds the ALU fi input and the single register-file write port.
//  Arbitrates ALU vs. memory writes through a one-entry holding buffer with valid/ready handshakes.
//  Sits between execute/memory stages and the register file.
// PARAMETERS
//  WIDTH   32  data width of results and register-file write data
//  AW       4  register address width (2**AW registers)
// PORTS
//  clk          in   1      system clock, all state on rising edge
//  reset_n      in   1      asynchronous, active-low reset
//  alu_valid    in   1      ALU result present this cycle
//  alu_ready    out  1      unit accepts ALU result this cycle
//  alu_rd       in   AW     destination register of ALU result
//  alu_res      in   WIDTH  ALU result value
//  alu_fo       in   8      ALU output flags
//  alu_wb_en    in   1      ALU result must be written to alu_rd
//  alu_flag_en  in   1      alu_fo must be loaded into flag register
//  mem_valid    in   1      load data present this cycle
//  mem_ready    out  1      unit accepts load data this cycle
//  mem_rd       in   AW     destination register of load
//  mem_data     in   WIDTH  load data
//  sfr_we       in   1      software write of flag register
//  sfr_wd       in   8      software flag value
//  flags        out  8      current flag register (to ALU fi)
//  rf_we        out  1      register-file write strobe (registered)
//  rf_wa        out  AW     register-file write address (registered)
//  rf_wd        out  WIDTH  register-file write data (registered)
//  hold_busy    out  1      holding buffer occupied
//  hold_rd      out  AW     destination held in buffer (valid when hold_busy)
// BEHAVIOUR
//  - Reset (async, reset_n=0): flags=8'h00, rf_we=0, rf_wa=0, rf_wd=0, hold empty; mid-operation reset discards held entry.
//  - Transfers: ALU xfer = alu_valid&alu_ready; mem xfer = mem_valid&mem_ready; evaluated at rising edge.
//  - alu_ready = !hold_busy; mem_ready = !hold_busy (buffer drain has absolute priority, no starvation).
//  - Write-port selection per cycle (priority order): hold entry; mem xfer; ALU xfer with alu_wb_en.
//  - ALU xfer with wb_en while mem xfer same cycle: mem written, ALU {rd,res} captured into hold, written next cycle.
//  - ALU result is younger than a concurrent load: same rd -> ALU value is final register content.
//  - ALU xfer with wb_en=0 never enters hold; flag_en=0 and wb_en=0 -> accepted and discarded.
//  - Selected write appears on rf_we/rf_wa/rf_wd the cycle after the xfer edge (latency 1; hold path latency 2).
//  - rf_we deasserts the cycle after no write was selected; rf_wa/rf_wd hold last value.
//  - Flags: ALU xfer with alu_flag_en loads alu_fo at the xfer edge (visible next cycle), independent of hold.
//  - sfr_we same edge as ALU flag load: sfr_wd wins. sfr_we honoured regardless of handshakes.
//  - hold_busy set at capture edge, cleared at the edge its write is issued; never holds more than one entry.
//  - No combinational path from alu_valid/mem_valid to alu_ready/mem_ready.
// TESTING
//  1 reset_n low mid-stream with hold_busy=1 -> flags=00, rf_we=0, hold_busy=0 immediately (async).
//  2 ALU only: rd=3,res=32'h1234_5678,wb_en=1,fo=8'h05,flag_en=1 -> next cycle rf_we=1,rf_wa=3,rf_wd=12345678, flags=05.
//  3 ALU rd=2 res=AA and mem rd=2 data=BB same cycle -> cycle+1 write r2=BB, hold_busy=1, ready both 0; cycle+2 write r2=AA.
//  4 back-to-back mem_valid for 4 cycles plus one colliding ALU -> ALU written exactly once, no load lost, order per rules.
//  5 sfr_we=1 sfr_wd=8'h0F with ALU flag_en fo=8'h02 same edge -> flags=0F; ALU wb_en=0,flag_en=0 -> no rf_we, flags unchanged.
//  6 random valid streams vs. scoreboard model -> final register image and flag sequence match, hold never overflows.

Source files
------------

// File: rtl/alu_wb_unit_if.sv
// alu_wb_unit_if: ALU-result and load-data handshake channels into the writeback unit.
interface alu_wb_unit_if #(parameter int WIDTH = 32, parameter int AW = 4);
    logic             alu_valid;
    logic             alu_ready;
    logic [AW-1:0]    alu_rd;
    logic [WIDTH-1:0] alu_res;
    logic [7:0]       alu_fo;
    logic             alu_wb_en;
    logic             alu_flag_en;
    logic             mem_valid;
    logic             mem_ready;
    logic [AW-1:0]    mem_rd;
    logic [WIDTH-1:0] mem_data;
    modport master (
        output alu_valid, alu_rd, alu_res, alu_fo, alu_wb_en, alu_flag_en,
        output mem_valid, mem_rd, mem_data,
        input  alu_ready, mem_ready
    );
    modport slave (
        input  alu_valid, alu_rd, alu_res, alu_fo, alu_wb_en, alu_flag_en,
        input  mem_valid, mem_rd, mem_data,
        output alu_ready, mem_ready
    );
endinterface

// File: rtl/alu_wb_unit.sv
// alu_wb_unit: writeback stage owning the flag register and the single register-file
// write port, arbitrating ALU and load writes through a one-entry holding buffer.
module alu_wb_unit #(
    parameter int WIDTH = 32,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    alu_wb_unit_if.slave     bus,
    input  logic             sfr_we,
    input  logic [7:0]       sfr_wd,
    output logic [7:0]       flags,
    output logic             rf_we,
    output logic [AW-1:0]    rf_wa,
    output logic [WIDTH-1:0] rf_wd,
    output logic             hold_busy,
    output logic [AW-1:0]    hold_rd
);
    logic [WIDTH-1:0] hold_data;
    logic             alu_x, mem_x, alu_w, capture, sel_we;
    logic [AW-1:0]    sel_wa;
    logic [WIDTH-1:0] sel_wd;
    // Ready depends only on buffer state, so valid never combinationally feeds ready.
    assign bus.alu_ready = !hold_busy;
    assign bus.mem_ready = !hold_busy;
    assign alu_x   = bus.alu_valid & !hold_busy;
    assign mem_x   = bus.mem_valid & !hold_busy;
    assign alu_w   = alu_x & bus.alu_wb_en;
    assign capture = mem_x & alu_w;
    assign sel_we  = hold_busy | mem_x | alu_w;
    assign sel_wa  = hold_busy ? hold_rd : mem_x ? bus.mem_rd : bus.alu_rd;
    assign sel_wd  = hold_busy ? hold_data : mem_x ? bus.mem_data : bus.alu_res;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags     <= 8'h00;
            rf_we     <= 1'b0;
            rf_wa     <= '0;
            rf_wd     <= '0;
            hold_busy <= 1'b0;
            hold_rd   <= '0;
            hold_data <= '0;
        end else begin
            flags     <= sfr_we ? sfr_wd : (alu_x & bus.alu_flag_en) ? bus.alu_fo : flags;
            rf_we     <= sel_we;
            hold_busy <= capture;
            if (sel_we) begin
                rf_wa <= sel_wa;
                rf_wd <= sel_wd;
            end
            // Younger ALU result parks here so it lands after the concurrent load.
            if (capture) begin
                hold_rd   <= bus.alu_rd;
                hold_data <= bus.alu_res;
            end
        end
    end
endmodule

// File: tb/tb_alu_wb_unit.sv
// tb_alu_wb_unit: scoreboard bench for alu_wb_unit; expected writes are queued when driven.
module tb_alu_wb_unit;
    typedef struct packed {
        logic [3:0]  wa;
        logic [31:0] wd;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sfr_we = 1'b0;
    logic [7:0]  sfr_wd = 8'h00;
    logic [7:0]  flags;
    logic        rf_we;
    logic [3:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        hold_busy;
    logic [3:0]  hold_rd;

    int checks = 0;
    int errors = 0;
    wr_t         sb[$];
    logic        m_hold = 1'b0;
    logic [3:0]  m_hrd = '0;
    logic [31:0] m_hd = '0;
    logic [7:0]  m_flags = 8'h00;
    logic [31:0] m_img[16];
    logic [31:0] d_img[16];

    alu_wb_unit_if #(.WIDTH(32), .AW(4)) bus ();

    alu_wb_unit #(.WIDTH(32), .AW(4)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus.slave),
        .sfr_we(sfr_we), .sfr_wd(sfr_wd), .flags(flags),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .hold_busy(hold_busy), .hold_rd(hold_rd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [3:0] ard, input logic [31:0] ares,
                         input logic [7:0] afo, input logic awb, input logic afe,
                         input logic mv, input logic [3:0] mrd, input logic [31:0] mdata,
                         input logic swe, input logic [7:0] swd);
        bus.alu_valid = av; bus.alu_rd = ard; bus.alu_res = ares; bus.alu_fo = afo;
        bus.alu_wb_en = awb; bus.alu_flag_en = afe;
        bus.mem_valid = mv; bus.mem_rd = mrd; bus.mem_data = mdata;
        sfr_we = swe; sfr_wd = swd;
    endtask

    task automatic push(input logic [3:0] wa, input logic [31:0] wd);
        sb.push_back('{wa: wa, wd: wd});
        m_img[wa] = wd;
    endtask

    // Called at posedge+1 with inputs already driven; models the next edge and checks the result.
    task automatic cycle();
        logic ax, mx, exp_we;
        logic [7:0] nf;
        wr_t w;
        check("alu_ready", {31'd0, bus.alu_ready}, {31'd0, !m_hold});
        check("mem_ready", {31'd0, bus.mem_ready}, {31'd0, !m_hold});
        ax = bus.alu_valid & !m_hold;
        mx = bus.mem_valid & !m_hold;
        exp_we = 1'b1;
        if (m_hold) begin
            push(m_hrd, m_hd);
            m_hold = 1'b0;
        end else if (mx) begin
            push(bus.mem_rd, bus.mem_data);
            if (ax & bus.alu_wb_en) begin
                m_hold = 1'b1; m_hrd = bus.alu_rd; m_hd = bus.alu_res;
            end
        end else if (ax & bus.alu_wb_en) begin
            push(bus.alu_rd, bus.alu_res);
        end else begin
            exp_we = 1'b0;
        end
        nf = sfr_we ? sfr_wd : (ax & bus.alu_flag_en) ? bus.alu_fo : m_flags;
        @(posedge clk); #1;
        m_flags = nf;
        check("rf_we", {31'd0, rf_we}, {31'd0, exp_we});
        if (rf_we) begin
            if (sb.size() == 0) begin
                check("sb_empty", 32'd1, 32'd0);
            end else begin
                w = sb.pop_front();
                check("rf_wa", {28'd0, rf_wa}, {28'd0, w.wa});
                check("rf_wd", rf_wd, w.wd);
            end
            d_img[rf_wa] = rf_wd;
        end
        check("flags", {24'd0, flags}, {24'd0, m_flags});
        check("hold_busy", {31'd0, hold_busy}, {31'd0, m_hold});
        if (m_hold) check("hold_rd", {28'd0, hold_rd}, {28'd0, m_hrd});
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
    endtask

    initial begin
        int sent;
        logic was_hold, alu_done;
        logic [3:0] ard, mrd;
        logic [31:0] ares, mdata;
        logic [7:0] afo;
        logic av, awb, afe, mv;
        for (int i = 0; i < 16; i++) begin
            m_img[i] = '0;
            d_img[i] = '0;
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #12;
        check("rst_flags", {24'd0, flags}, 32'h0);
        check("rst_rf_we", {31'd0, rf_we}, 32'h0);
        check("rst_rf_wa", {28'd0, rf_wa}, 32'h0);
        check("rst_rf_wd", rf_wd, 32'h0);
        check("rst_hold", {31'd0, hold_busy}, 32'h0);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;

        // ALU only write with flag load
        drive(1, 3, 32'h1234_5678, 8'h05, 1, 1, 0, 0, 0, 0, 0);
        cycle();
        check("t2_wa", {28'd0, rf_wa}, 32'd3);
        check("t2_wd", rf_wd, 32'h1234_5678);
        check("t2_flags", {24'd0, flags}, 32'h05);
        idle();

        // Collision on same rd: load first, ALU from hold next
        drive(1, 2, 32'hAA, 8'h00, 1, 0, 1, 2, 32'hBB, 0, 0);
        cycle();
        check("t3_wd1", rf_wd, 32'hBB);
        check("t3_busy", {31'd0, hold_busy}, 32'd1);
        check("t3_ready", {30'd0, bus.alu_ready, bus.mem_ready}, 32'd0);
        idle();
        check("t3_wd2", rf_wd, 32'hAA);
        check("t3_wa2", {28'd0, rf_wa}, 32'd2);
        idle();
        check("t3_r2", m_img[2], 32'hAA);

        // sfr write beats ALU flag load; discarded ALU result
        drive(1, 7, 32'h77, 8'h02, 0, 1, 0, 0, 0, 1, 8'h0F);
        cycle();
        check("t5_flags", {24'd0, flags}, 32'h0F);
        drive(1, 8, 32'h88, 8'h33, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        check("t5_nowr", {31'd0, rf_we}, 32'd0);
        check("t5_flags2", {24'd0, flags}, 32'h0F);

        // Four back-to-back loads with one colliding ALU result, loads retried while stalled
        sent = 0; alu_done = 1'b0;
        while (sent < 4) begin
            was_hold = m_hold;
            drive(sent == 1 && !alu_done, 4'hC, 32'hC0DE, 8'h00, 1, 0,
                  1, 4'(4 + sent), 32'h100 + sent, 0, 0);
            cycle();
            if (!was_hold) begin
                if (sent == 1) alu_done = 1'b1;
                sent++;
            end
        end
        idle(); idle();
        check("t4_alu", d_img[12], 32'hC0DE);
        for (int i = 0; i < 4; i++) check("t4_load", d_img[4 + i], 32'h100 + i);

        // Async reset while the buffer is occupied
        drive(1, 9, 32'h99, 8'h44, 1, 1, 1, 10, 32'hAB, 0, 0);
        cycle();
        check("t1_pre", {31'd0, hold_busy}, 32'd1);
        idle();
        drive(1, 9, 32'h99, 8'h44, 1, 1, 1, 10, 32'hAB, 0, 0);
        cycle();
        #2 reset_n = 1'b0;
        #1;
        check("t1_flags", {24'd0, flags}, 32'h0);
        check("t1_rf_we", {31'd0, rf_we}, 32'h0);
        check("t1_hold", {31'd0, hold_busy}, 32'h0);
        m_hold = 1'b0; m_flags = 8'h00; sb.delete();
        m_img[9] = d_img[9];
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;

        // Random streams; a stalled master keeps its request stable
        av = 0; ard = 0; ares = 0; afo = 0; awb = 0; afe = 0;
        mv = 0; mrd = 0; mdata = 0;
        for (int n = 0; n < 400; n++) begin
            if (!m_hold) begin
                av = $urandom_range(0, 1); ard = 4'($urandom_range(0, 15)); ares = $urandom;
                afo = 8'($urandom); awb = $urandom_range(0, 3) != 0; afe = $urandom_range(0, 1);
                mv = $urandom_range(0, 1); mrd = 4'($urandom_range(0, 15)); mdata = $urandom;
            end
            drive(av, ard, ares, afo, awb, afe, mv, mrd, mdata,
                  $urandom_range(0, 7) == 0, 8'($urandom));
            cycle();
        end
        idle(); idle();
        for (int i = 0; i < 16; i++) check("img", d_img[i], m_img[i]);
        check("sb_left", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
